// File: rtl/rv64_exec_pkg.sv
// rv64_exec_pkg: operation codes, memory size codes and datapath helpers for the RV64IM execute stage.
package rv64_exec_pkg;
  typedef enum logic [5:0] {
    OP_NOP,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW, OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
  } exec_op_t;
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;
  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
  // Divide-by-zero and signed-overflow results are fixed by the ISA, not by the divider.
  function automatic logic [63:0] div64(input logic [63:0] a, input logic [63:0] b, input logic sgn, input logic rem);
    if (b == '0) return rem ? a : '1;
    if (sgn && a == {1'b1, 63'b0} && b == '1) return rem ? '0 : a;
    if (sgn) return rem ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    return rem ? a % b : a / b;
  endfunction
  // Extending 32-bit operands to 64 bits keeps the word corner cases exact after truncation.
  function automatic logic [63:0] divw(input logic [31:0] a, input logic [31:0] b, input logic sgn, input logic rem);
    logic [63:0] q;
    q = div64(sgn ? sx32(a) : {32'b0, a}, sgn ? sx32(b) : {32'b0, b}, sgn, rem);
    return sx32(q[31:0]);
  endfunction
  function automatic string abi_name(input logic [4:0] idx);
    if (idx == 5'd0) return "zero";
    if (idx == 5'd1) return "ra";
    if (idx == 5'd2) return "sp";
    if (idx == 5'd3) return "gp";
    if (idx == 5'd4) return "tp";
    if (idx <= 5'd7) return $sformatf("t%0d", idx - 5'd5);
    if (idx <= 5'd9) return $sformatf("s%0d", idx - 5'd8);
    if (idx <= 5'd17) return $sformatf("a%0d", idx - 5'd10);
    if (idx <= 5'd27) return $sformatf("s%0d", idx - 5'd16);
    return $sformatf("t%0d", idx - 5'd25);
  endfunction
endpackage

// File: rtl/rv64_regfile.sv
// rv64_regfile: 32x64 register file, two operand read ports, one write port, one debug port, x0 fixed at zero.
module rv64_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_dbg,
  input  logic        i_we,
  input  logic [4:0]  i_rd,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_rs1,
  output logic [63:0] o_rs2,
  output logic [63:0] o_dbg
);
  logic [63:0] r_x [32];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < 32; i++) r_x[i] <= '0;
    else if (i_we && i_rd != 5'd0) r_x[i_rd] <= i_wdata;
  end
  assign o_rs1 = r_x[i_rs1];
  assign o_rs2 = r_x[i_rs2];
  assign o_dbg = rst ? '0 : r_x[i_dbg];
endmodule

// File: rtl/rv64_exec_unit.sv
// rv64_exec_unit: single-issue RV64IM execute stage with integrated register file,
// combinational data-memory port and jump reporting.
module rv64_exec_unit
  import rv64_exec_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [5:0]      op,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [1:0]      mem_size,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            jump_valid,
  output logic [XLEN-1:0] jump_target,
  input  logic [4:0]      dbg_idx,
  output logic [XLEN-1:0] dbg_data
);
  exec_op_t     w_op;
  logic [63:0]  w_a, w_b, w_o2, w_res, w_u, w_pc4, w_agen;
  logic [127:0] w_ma, w_mb, w_prod;
  logic         w_wr, w_imm_form, w_jump;
  assign w_op = exec_op_t'(op);
  assign w_imm_form = w_op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI,
                                   OP_SRLI, OP_SRAI, OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW};
  assign w_o2 = w_imm_form ? imm : w_b;
  assign w_u = {{32{imm[19]}}, imm[19:0], 12'b0};
  assign w_pc4 = pc + 64'd4;
  assign w_agen = w_a + imm;
  // One 128-bit multiplier serves every high-half variant via operand extension.
  assign w_ma = (w_op == OP_MULH || w_op == OP_MULHSU) ? {{64{w_a[63]}}, w_a} : {64'b0, w_a};
  assign w_mb = (w_op == OP_MULH) ? {{64{w_o2[63]}}, w_o2} : {64'b0, w_o2};
  assign w_prod = w_ma * w_mb;
  always_comb begin
    w_res = '0;
    w_wr = 1'b1;
    case (w_op)
      OP_ADD, OP_ADDI:   w_res = w_a + w_o2;
      OP_SUB:            w_res = w_a - w_o2;
      OP_SLL, OP_SLLI:   w_res = w_a << w_o2[5:0];
      OP_SLT, OP_SLTI:   w_res = {63'b0, $signed(w_a) < $signed(w_o2)};
      OP_SLTU, OP_SLTIU: w_res = {63'b0, w_a < w_o2};
      OP_XOR, OP_XORI:   w_res = w_a ^ w_o2;
      OP_SRL, OP_SRLI:   w_res = w_a >> w_o2[5:0];
      OP_SRA, OP_SRAI:   w_res = $signed(w_a) >>> w_o2[5:0];
      OP_OR, OP_ORI:     w_res = w_a | w_o2;
      OP_AND, OP_ANDI:   w_res = w_a & w_o2;
      OP_ADDW, OP_ADDIW: w_res = sx32(w_a[31:0] + w_o2[31:0]);
      OP_SUBW:           w_res = sx32(w_a[31:0] - w_o2[31:0]);
      OP_SLLW, OP_SLLIW: w_res = sx32(w_a[31:0] << w_o2[4:0]);
      OP_SRLW, OP_SRLIW: w_res = sx32(w_a[31:0] >> w_o2[4:0]);
      OP_SRAW, OP_SRAIW: w_res = sx32($signed(w_a[31:0]) >>> w_o2[4:0]);
      OP_MUL:            w_res = w_prod[63:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_res = w_prod[127:64];
      OP_DIV:            w_res = div64(w_a, w_o2, 1'b1, 1'b0);
      OP_DIVU:           w_res = div64(w_a, w_o2, 1'b0, 1'b0);
      OP_REM:            w_res = div64(w_a, w_o2, 1'b1, 1'b1);
      OP_REMU:           w_res = div64(w_a, w_o2, 1'b0, 1'b1);
      OP_MULW:           w_res = sx32(w_a[31:0] * w_o2[31:0]);
      OP_DIVW:           w_res = divw(w_a[31:0], w_o2[31:0], 1'b1, 1'b0);
      OP_DIVUW:          w_res = divw(w_a[31:0], w_o2[31:0], 1'b0, 1'b0);
      OP_REMW:           w_res = divw(w_a[31:0], w_o2[31:0], 1'b1, 1'b1);
      OP_REMUW:          w_res = divw(w_a[31:0], w_o2[31:0], 1'b0, 1'b1);
      OP_LUI:            w_res = w_u;
      OP_AUIPC:          w_res = pc + w_u;
      OP_JAL, OP_JALR:   w_res = w_pc4;
      OP_LB:             w_res = {{56{mem_rdata[7]}}, mem_rdata[7:0]};
      OP_LH:             w_res = {{48{mem_rdata[15]}}, mem_rdata[15:0]};
      OP_LW:             w_res = sx32(mem_rdata[31:0]);
      OP_LD:             w_res = mem_rdata;
      OP_LBU:            w_res = {56'b0, mem_rdata[7:0]};
      OP_LHU:            w_res = {48'b0, mem_rdata[15:0]};
      OP_LWU:            w_res = {32'b0, mem_rdata[31:0]};
      default:           w_wr = 1'b0;
    endcase
  end
  assign w_jump = w_op inside {OP_JAL, OP_JALR};
  assign jump_valid = op_valid && !reset && w_jump;
  assign jump_target = (w_op == OP_JAL) ? imm : {w_agen[63:1], 1'b0};
  assign mem_addr = w_agen;
  assign mem_we = op_valid && !reset && (w_op inside {OP_SB, OP_SH, OP_SW, OP_SD});
  assign mem_wdata = w_b;
  assign mem_size = (w_op inside {OP_LB, OP_LBU, OP_SB}) ? MEM_B :
                    (w_op inside {OP_LH, OP_LHU, OP_SH}) ? MEM_H :
                    (w_op inside {OP_LW, OP_LWU, OP_SW}) ? MEM_W : MEM_D;
  rv64_regfile u_rf (
    .clk     (clk),
    .rst     (reset),
    .i_rs1   (rs1),
    .i_rs2   (rs2),
    .i_dbg   (dbg_idx),
    .i_we    (op_valid && w_wr),
    .i_rd    (rd),
    .i_wdata (w_res),
    .o_rs1   (w_a),
    .o_rs2   (w_b),
    .o_dbg   (dbg_data)
  );
endmodule

// File: tb/tb_rv64_exec_unit.sv
// tb_rv64_exec_unit: table-driven directed vectors plus hand-written memory, jump and reset sequences.
module tb_rv64_exec_unit;
  import rv64_exec_pkg::*;
  logic        clk, reset, op_valid, mem_we, jump_valid;
  logic [5:0]  op;
  logic [4:0]  rd, rs1, rs2, dbg_idx;
  logic [1:0]  mem_size;
  logic [63:0] imm, pc, mem_addr, mem_wdata, mem_rdata, jump_target, dbg_data;
  int n_pass = 0, n_total = 0;
  typedef struct {
    exec_op_t    op;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm, pc, rdata, exp;
  } vec_t;
  vec_t vq[$];
  rv64_exec_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .pc(pc), .mem_addr(mem_addr), .mem_we(mem_we), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .jump_valid(jump_valid),
    .jump_target(jump_target), .dbg_idx(dbg_idx), .dbg_data(dbg_data)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic chk_s(input string nm, input string act, input string exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %s expected %s", nm, act, exp);
  endtask
  task automatic add(input exec_op_t o, input int d, input int s1, input int s2,
                     input logic [63:0] im, input logic [63:0] ex,
                     input logic [63:0] rdt = 64'd0, input logic [63:0] p = 64'd0);
    vec_t v;
    v.op = o; v.rd = 5'(d); v.rs1 = 5'(s1); v.rs2 = 5'(s2);
    v.imm = im; v.exp = ex; v.rdata = rdt; v.pc = p;
    vq.push_back(v);
  endtask
  task automatic drive(input logic [5:0] o, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [63:0] im, input logic [63:0] p, input logic [63:0] rdt);
    @(negedge clk);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; pc = p; mem_rdata = rdt; op_valid = 1'b1;
    #1;
  endtask
  task automatic commit();
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask
  task automatic chk_reg(input string nm, input logic [4:0] idx, input logic [63:0] exp);
    dbg_idx = idx;
    #1;
    chk(nm, dbg_data, exp);
  endtask
  initial begin
    add(OP_ADDI, 1, 0, 0, 64'd5, 64'd5);
    add(OP_ADDI, 2, 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE);
    add(OP_ADDI, 3, 0, 0, 64'd1, 64'd1);
    add(OP_SLLI, 3, 3, 0, 64'd63, 64'h8000_0000_0000_0000);
    add(OP_SLT, 4, 3, 1, 64'd0, 64'd1);
    add(OP_SLTU, 4, 3, 1, 64'd0, 64'd0);
    add(OP_ADDI, 5, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    add(OP_SRLI, 5, 5, 0, 64'd33, 64'h7FFF_FFFF);
    add(OP_ADDI, 6, 0, 0, 64'd1, 64'd1);
    add(OP_ADDW, 7, 5, 6, 64'd0, 64'hFFFF_FFFF_8000_0000);
    add(OP_ADDI, 8, 0, 0, 64'd1, 64'd1);
    add(OP_SLLI, 8, 8, 0, 64'd31, 64'h8000_0000);
    add(OP_SRAIW, 9, 8, 0, 64'd4, 64'hFFFF_FFFF_F800_0000);
    add(OP_DIV, 10, 1, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    add(OP_REM, 10, 1, 0, 64'd0, 64'd5);
    add(OP_ADDI, 11, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    add(OP_DIV, 12, 3, 11, 64'd0, 64'h8000_0000_0000_0000);
    add(OP_REM, 12, 3, 11, 64'd0, 64'd0);
    add(OP_ADDI, 14, 0, 0, 64'hFFFF_FFFF_FFFF_FFE9, 64'hFFFF_FFFF_FFFF_FFE9);
    add(OP_DIV, 13, 14, 1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC);
    add(OP_REM, 13, 14, 1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD);
    add(OP_DIVU, 13, 14, 1, 64'd0, 64'h3333_3333_3333_332E);
    add(OP_REMU, 13, 14, 1, 64'd0, 64'd3);
    add(OP_MUL, 15, 14, 1, 64'd0, 64'hFFFF_FFFF_FFFF_FF8D);
    add(OP_MULHU, 15, 11, 11, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    add(OP_MULH, 15, 11, 11, 64'd0, 64'd0);
    add(OP_MULHSU, 15, 11, 11, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    add(OP_MULW, 15, 8, 6, 64'd0, 64'hFFFF_FFFF_8000_0000);
    add(OP_DIVW, 15, 14, 1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC);
    add(OP_DIVUW, 15, 8, 1, 64'd0, 64'h1999_9999);
    add(OP_REMUW, 15, 8, 1, 64'd0, 64'd3);
    add(OP_REMW, 15, 14, 1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD);
    add(OP_SRA, 16, 3, 6, 64'd0, 64'hC000_0000_0000_0000);
    add(OP_SRAI, 16, 3, 0, 64'd4, 64'hF800_0000_0000_0000);
    add(OP_SRL, 16, 3, 6, 64'd0, 64'h4000_0000_0000_0000);
    add(OP_SLL, 16, 6, 5, 64'd0, 64'h8000_0000_0000_0000);
    add(OP_SLLW, 16, 6, 5, 64'd0, 64'hFFFF_FFFF_8000_0000);
    add(OP_SRLW, 16, 11, 6, 64'd0, 64'h7FFF_FFFF);
    add(OP_SRAW, 16, 11, 6, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    add(OP_XORI, 16, 1, 0, 64'd3, 64'd6);
    add(OP_ORI, 16, 1, 0, 64'd8, 64'd13);
    add(OP_ANDI, 16, 1, 0, 64'd4, 64'd4);
    add(OP_SLTI, 16, 2, 0, 64'd0, 64'd1);
    add(OP_SLTIU, 16, 2, 0, 64'd1, 64'd0);
    add(OP_SLTIU, 16, 1, 0, 64'd6, 64'd1);
    add(OP_SUB, 16, 1, 6, 64'd0, 64'd4);
    add(OP_SUBW, 16, 8, 6, 64'd0, 64'h7FFF_FFFF);
    add(OP_AUIPC, 16, 0, 0, 64'd1, 64'h2000, 64'd0, 64'h1000);
    add(OP_LUI, 16, 0, 0, 64'h12345, 64'h1234_5000);
    add(OP_LUI, 16, 0, 0, 64'h80000, 64'hFFFF_FFFF_8000_0000);
    add(OP_ADDIW, 16, 5, 0, 64'd1, 64'hFFFF_FFFF_8000_0000);
    add(OP_SLLIW, 16, 6, 0, 64'd31, 64'hFFFF_FFFF_8000_0000);
    add(OP_SRLIW, 16, 11, 0, 64'd4, 64'h0FFF_FFFF);
    add(OP_XOR, 16, 1, 6, 64'd0, 64'd4);
    add(OP_OR, 16, 1, 8, 64'd0, 64'h8000_0005);
    add(OP_AND, 16, 11, 1, 64'd0, 64'd5);
    add(OP_LB, 17, 0, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 64'h80);
    add(OP_LBU, 17, 0, 0, 64'd0, 64'h80, 64'h80);
    add(OP_LH, 17, 0, 0, 64'd0, 64'hFFFF_FFFF_FFFF_8001, 64'h8001);
    add(OP_LHU, 17, 0, 0, 64'd0, 64'h8001, 64'h8001);
    add(OP_LW, 17, 0, 0, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000);
    add(OP_LWU, 17, 0, 0, 64'd0, 64'h8000_0000, 64'h8000_0000);
    add(OP_LD, 17, 0, 0, 64'd0, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788);
    add(OP_ADD, 17, 17, 17, 64'd0, 64'h2244_6688_AACC_EF10);
    add(OP_ADDI, 0, 0, 0, 64'd5, 64'd0);
    add(OP_BEQ, 20, 1, 1, 64'd8, 64'd0);
    add(OP_SB, 20, 1, 1, 64'd0, 64'd0);
    add(OP_NOP, 20, 1, 1, 64'd3, 64'd0);
    reset = 1'b1; op_valid = 1'b1; op = OP_SD; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0;
    imm = 64'd0; pc = 64'd0; mem_rdata = 64'd0; dbg_idx = 5'd0;
    #1;
    chk("reset_mem_we", {63'b0, mem_we}, 64'd0);
    op = OP_JAL;
    #1;
    chk("reset_jump_valid", {63'b0, jump_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_reg("reset_x1", 5'd1, 64'd0);
    @(negedge clk);
    reset = 1'b0; op_valid = 1'b0;
    chk_reg("post_reset_x31", 5'd31, 64'd0);
    foreach (vq[i]) begin
      drive(vq[i].op, vq[i].rd, vq[i].rs1, vq[i].rs2, vq[i].imm, vq[i].pc, vq[i].rdata);
      commit();
      chk_reg($sformatf("v%0d_%s", i, vq[i].op.name()), vq[i].rd, vq[i].exp);
    end
    drive(6'd63, 5'd20, 5'd1, 5'd1, 64'd1, 64'd0, 64'd0);
    chk("unknown_mem_we", {63'b0, mem_we}, 64'd0);
    chk("unknown_jump", {63'b0, jump_valid}, 64'd0);
    commit();
    chk_reg("unknown_x20", 5'd20, 64'd0);
    drive(OP_SD, 5'd1, 5'd1, 5'd2, 64'd8, 64'd0, 64'd0);
    chk("sd_mem_we", {63'b0, mem_we}, 64'd1);
    chk("sd_mem_addr", mem_addr, 64'd13);
    chk("sd_mem_size", {62'b0, mem_size}, 64'd3);
    chk("sd_mem_wdata", mem_wdata, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sd_jump", {63'b0, jump_valid}, 64'd0);
    commit();
    chk_reg("sd_x1_kept", 5'd1, 64'd5);
    chk_reg("sd_x2_kept", 5'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    drive(OP_LW, 5'd17, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0);
    chk("lw_mem_addr", mem_addr, 64'd4);
    chk("lw_mem_size", {62'b0, mem_size}, 64'd2);
    chk("lw_mem_we", {63'b0, mem_we}, 64'd0);
    commit();
    drive(OP_SH, 5'd0, 5'd1, 5'd2, 64'd0, 64'd0, 64'd0);
    chk("sh_mem_size", {62'b0, mem_size}, 64'd1);
    chk("sh_mem_we", {63'b0, mem_we}, 64'd1);
    commit();
    drive(OP_ADDI, 5'd2, 5'd0, 5'd0, 64'h200, 64'd0, 64'd0);
    commit();
    drive(OP_JALR, 5'd1, 5'd2, 5'd0, 64'd3, 64'h100, 64'd0);
    chk("jalr_valid", {63'b0, jump_valid}, 64'd1);
    chk("jalr_target", jump_target, 64'h202);
    commit();
    chk_reg("jalr_x1", 5'd1, 64'h104);
    drive(OP_JALR, 5'd2, 5'd2, 5'd0, 64'd0, 64'h300, 64'd0);
    chk("jalr_self_target", jump_target, 64'h200);
    commit();
    chk_reg("jalr_self_x2", 5'd2, 64'h304);
    drive(OP_JAL, 5'd5, 5'd0, 5'd0, 64'h4000, 64'h10, 64'd0);
    chk("jal_valid", {63'b0, jump_valid}, 64'd1);
    chk("jal_target", jump_target, 64'h4000);
    commit();
    chk_reg("jal_x5", 5'd5, 64'h14);
    drive(OP_SD, 5'd0, 5'd1, 5'd2, 64'd0, 64'd0, 64'd0);
    op_valid = 1'b0;
    #1;
    chk("idle_mem_we", {63'b0, mem_we}, 64'd0);
    op = OP_JAL;
    #1;
    chk("idle_jump", {63'b0, jump_valid}, 64'd0);
    op = OP_ADDI; rd = 5'd20; imm = 64'd9;
    commit();
    chk_reg("idle_no_write", 5'd20, 64'd0);
    drive(OP_ADDI, 5'd21, 5'd0, 5'd0, 64'd9, 64'd0, 64'd0);
    dbg_idx = 5'd2;
    reset = 1'b1;
    #1;
    chk("midreset_dbg", dbg_data, 64'd0);
    chk("midreset_mem_we", {63'b0, mem_we}, 64'd0);
    commit();
    reset = 1'b0;
    chk_reg("midreset_x21_dropped", 5'd21, 64'd0);
    chk_reg("midreset_x1_cleared", 5'd1, 64'd0);
    drive(OP_ADDI, 5'd22, 5'd0, 5'd0, 64'd7, 64'd0, 64'd0);
    commit();
    chk_reg("after_reset_write", 5'd22, 64'd7);
    chk_s("abi0", abi_name(5'd0), "zero");
    chk_s("abi2", abi_name(5'd2), "sp");
    chk_s("abi8", abi_name(5'd8), "s0");
    chk_s("abi10", abi_name(5'd10), "a0");
    chk_s("abi27", abi_name(5'd27), "s11");
    chk_s("abi31", abi_name(5'd31), "t6");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
